instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- Fetch stage that produces the PC and instruction stream consumed by the IF/ID pipeline register.
- Owns the program counter and runs a req/ack handshake to instruction memory, which may insert wait states.
- Honours freeze from the hazard unit and branch redirects from EX.
- Inserts bubbles (instruction 0, pc 0) whenever no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (word aligned)
NOP_INSTR, 32'h0000_0000, bubble value driven on instruction when invalid

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
freeze  in  1  hazard stall; hold presented outputs, do not advance
branch_taken  in  1  one-cycle redirect pulse from EX
branch_address  in  32  redirect target; bits [1:0] forced to 0
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch address, stable while imem_req=1
imem_ack  in  1  one-cycle response; may coincide with first req cycle (zero-wait)
imem_rdata  in  32  instruction, valid only when imem_ack=1
pc  out  32  fetched address + 4, registered
instruction  out  32  fetched instruction, registered
instr_valid  out  1  pc/instruction hold a real fetch

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, next_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - pc=0, instruction=NOP_INSTR, instr_valid=0, hold buffer empty.
  - Reset mid-request abandons the request; a late imem_ack while IDLE is ignored.
- States:
  - IDLE: next cycle → REQ; imem_addr<=next_pc.
  - REQ: imem_req=1.
    - ack & !freeze: pc<=imem_addr+4, instruction<=imem_rdata, instr_valid<=1, imem_addr<=imem_addr+4; stay in REQ. Throughput is 1 instr/cycle with zero-wait memory.
    - ack & freeze: capture rdata and addr+4 into the hold buffer; outputs unchanged; → HOLD with imem_req=0.
    - no ack & !freeze: outputs <= bubble (pc=0, NOP_INSTR, valid=0).
    - no ack & freeze: outputs unchanged.
  - HOLD: imem_req=0; outputs unchanged while freeze=1. When freeze=0: outputs<=buffer, valid<=1, imem_addr<=buffered pc → REQ.
  - DISCARD: entered on a branch while a request is outstanding and unacked.
    - imem_req=1; old imem_addr held stable per protocol.
    - On ack: drop the response, imem_addr<=redirect target → REQ.
    - Outputs stay bubble.
- Branch (priority over freeze and ack; takes effect at the posedge where branch_taken=1):
  - Outputs <= bubble regardless of freeze; hold buffer cleared.
  - Redirect target = {branch_address[31:2],2'b00}.
  - REQ with ack in the same cycle: response dropped; imem_addr<=target; stay in REQ.
  - REQ without ack: save target → DISCARD.
  - HOLD or IDLE: imem_addr<=target → REQ.
  - DISCARD: target overwritten by the newest branch.
- Arithmetic: +4 is modulo 2^32 (0xFFFF_FFFC → 0x0000_0000), no error.
- imem_addr never changes while imem_req=1 and no ack has arrived.

Decomposition:
- Shared pipeline package holds:
  - the fetch state enum (IDLE, REQ, HOLD, DISCARD),
  - the NOP/bubble constant,
  - PC_STEP=4,
  - the alignment mask.
- Single module; the hold buffer plus state logic stays inline, no sub-module.

Test Plan:
- Reset, then zero-wait memory (ack same cycle as req) → imem_addr 0,4,8,...; pc 4,8,12 on consecutive cycles, instr_valid=1.
- 2 wait states per fetch → imem_addr stable across wait cycles; two bubble cycles (instruction=0, valid=0) between valid outputs.
- Ack arrives while freeze=1, freeze held 3 cycles → outputs frozen, imem_req=0; on release the buffered instruction is presented and the next req is to addr+4.
- Branch to 0x0000_0103 while req to 0x20 is unacked, ack 2 cycles later with 0xDEAD_BEEF → 0xDEAD_BEEF never presented; next imem_addr=0x100; first valid pc=0x104.
- Branch coincident with freeze=1 and a held buffer → bubble output, buffer discarded, fetch resumes at target.
- rst asserted mid-request, then a late ack → state IDLE, outputs bubble, first fetch after reset at RESET_PC; next_pc wraps 0xFFFF_FFFC → 0.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM states, bubble value, PC step and
// word-alignment helper used by the instruction fetch stage.
package instruction_fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_HOLD    = 2'd2,
        FETCH_DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;
    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_addr(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake to
// instruction memory, and honours freeze and branch redirects.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_BUBBLE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        freeze_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_address_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic        instr_valid_o
);

    fetch_state_e state_q, state_d;

    logic [31:0] next_pc_q,    next_pc_d;
    logic [31:0] imem_addr_q,  imem_addr_d;
    logic [31:0] redirect_q,   redirect_d;
    logic [31:0] hold_pc_q,    hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] instr_q,      instr_d;
    logic        valid_q,      valid_d;

    logic [31:0] target;
    logic [31:0] addr_plus;

    assign target    = align_addr(branch_address_i);
    assign addr_plus = imem_addr_q + PC_STEP;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Branch has priority over everything; a branch with an unacked request
    // must wait out the in-flight response in DISCARD.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_IDLE: state_d = FETCH_REQ;
            FETCH_REQ: begin
                if (branch_taken_i) begin
                    state_d = imem_ack_i ? FETCH_REQ : FETCH_DISCARD;
                end else if (imem_ack_i && freeze_i) begin
                    state_d = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                if (branch_taken_i || !freeze_i) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_DISCARD: begin
                if (imem_ack_i) begin
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_comb begin
        next_pc_d    = next_pc_q;
        imem_addr_d  = imem_addr_q;
        redirect_d   = redirect_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        valid_d      = valid_q;

        if (branch_taken_i) begin
            pc_d         = 32'h0;
            instr_d      = NOP_INSTR;
            valid_d      = 1'b0;
            hold_pc_d    = 32'h0;
            hold_instr_d = NOP_INSTR;
        end

        unique case (state_q)
            FETCH_IDLE: begin
                imem_addr_d = branch_taken_i ? target : next_pc_q;
            end
            FETCH_REQ: begin
                if (branch_taken_i) begin
                    if (imem_ack_i) begin
                        imem_addr_d = target;
                    end else begin
                        redirect_d = target;
                    end
                end else if (imem_ack_i) begin
                    if (!freeze_i) begin
                        pc_d        = addr_plus;
                        instr_d     = imem_rdata_i;
                        valid_d     = 1'b1;
                        imem_addr_d = addr_plus;
                        next_pc_d   = addr_plus;
                    end else begin
                        hold_pc_d    = addr_plus;
                        hold_instr_d = imem_rdata_i;
                    end
                end else if (!freeze_i) begin
                    pc_d    = 32'h0;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            FETCH_HOLD: begin
                if (branch_taken_i) begin
                    imem_addr_d = target;
                end else if (!freeze_i) begin
                    pc_d         = hold_pc_q;
                    instr_d      = hold_instr_q;
                    valid_d      = 1'b1;
                    imem_addr_d  = hold_pc_q;
                    next_pc_d    = hold_pc_q;
                    hold_pc_d    = 32'h0;
                    hold_instr_d = NOP_INSTR;
                end
            end
            FETCH_DISCARD: begin
                // The newest branch wins even if it lands on the dropped ack.
                if (branch_taken_i) begin
                    redirect_d = target;
                end
                if (imem_ack_i) begin
                    imem_addr_d = branch_taken_i ? target : redirect_q;
                end
            end
            default: begin
                imem_addr_d = next_pc_q;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            next_pc_q    <= RESET_PC;
            imem_addr_q  <= RESET_PC;
            redirect_q   <= RESET_PC;
            hold_pc_q    <= 32'h0;
            hold_instr_q <= NOP_INSTR;
            pc_q         <= 32'h0;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
        end else begin
            next_pc_q    <= next_pc_d;
            imem_addr_q  <= imem_addr_d;
            redirect_q   <= redirect_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
        end
    end

    always_comb begin
        imem_req_o    = (state_q == FETCH_REQ) || (state_q == FETCH_DISCARD);
        imem_addr_o   = imem_addr_q;
        pc_o          = pc_q;
        instruction_o = instr_q;
        instr_valid_o = valid_q;
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed scenarios plus a
// randomized run compared against a flag-based behavioural model.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    bit          m_started, m_busy, m_dropping, m_held;
    logic [31:0] m_addr, m_target, m_held_pc, m_held_instr;
    logic [31:0] m_pc, m_instr;
    logic        m_valid;

    instruction_fetch_stage dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .freeze_i         (freeze),
        .branch_taken_i   (branch_taken),
        .branch_address_i (branch_address),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_ack_i       (imem_ack),
        .imem_rdata_i     (imem_rdata),
        .pc_o             (pc),
        .instruction_o    (instruction),
        .instr_valid_o    (instr_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_address = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_started = 0; m_busy = 0; m_dropping = 0; m_held = 0;
        m_addr = 32'h0; m_target = 32'h0; m_held_pc = 32'h0; m_held_instr = 32'h0;
        m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    endtask

    // Applies one clock's worth of the fetch rules to the model.
    task automatic model_step(input bit fz, input bit br, input logic [31:0] baddr,
                              input bit ack, input logic [31:0] rdata);
        logic [31:0] tgt;
        tgt = {baddr[31:2], 2'b00};
        if (br) begin
            m_pc = 0; m_instr = 0; m_valid = 0; m_held = 0;
            if (!m_busy) begin
                m_addr = tgt; m_busy = 1; m_started = 1;
            end else if (ack) begin
                m_addr = tgt; m_dropping = 0;
            end else begin
                m_dropping = 1; m_target = tgt;
            end
        end else if (!m_started) begin
            m_started = 1; m_busy = 1;
        end else if (m_held) begin
            if (!fz) begin
                m_pc = m_held_pc; m_instr = m_held_instr; m_valid = 1;
                m_addr = m_held_pc; m_held = 0; m_busy = 1;
            end
        end else if (m_dropping) begin
            if (ack) begin
                m_addr = m_target; m_dropping = 0;
            end
        end else if (ack) begin
            if (!fz) begin
                m_pc = m_addr + 4; m_instr = rdata; m_valid = 1; m_addr = m_addr + 4;
            end else begin
                m_held = 1; m_held_pc = m_addr + 4; m_held_instr = rdata; m_busy = 0;
            end
        end else if (!fz) begin
            m_pc = 0; m_instr = 0; m_valid = 0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
        checks++; if (pc !== 32'h0 || instruction !== 32'h0 || instr_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out got pc=%h instr=%h v=%b exp 0/0/0", pc, instruction, instr_valid);
        end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL first_req got req=%b addr=%h exp 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++; if (imem_addr !== 32'(4 * k)) begin errors++; $display("[TB] FAIL zw_addr got=%h exp=%h", imem_addr, 32'(4 * k)); end
            imem_ack = 1'b1; imem_rdata = 32'hA000_0000 + 32'(k);
            tick();
            checks++; if (pc !== 32'(4 * k + 4) || instruction !== 32'hA000_0000 + 32'(k) || instr_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL zw_out got pc=%h instr=%h v=%b exp pc=%h", pc, instruction, instr_valid, 32'(4 * k + 4));
            end
        end
        clear_inputs();
    endtask

    task automatic test_wait_states();
        do_reset();
        tick();
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 2; w++) begin
                imem_ack = 1'b0;
                tick();
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                    errors++; $display("[TB] FAIL ws_addr got req=%b addr=%h exp addr=%h", imem_req, imem_addr, 32'(4 * k));
                end
                checks++; if (instr_valid !== 1'b0 || instruction !== 32'h0 || pc !== 32'h0) begin
                    errors++; $display("[TB] FAIL ws_bubble got pc=%h instr=%h v=%b exp bubble", pc, instruction, instr_valid);
                end
            end
            imem_ack = 1'b1; imem_rdata = 32'hB000_0000 + 32'(k);
            tick();
            checks++; if (instr_valid !== 1'b1 || pc !== 32'(4 * k + 4) || instruction !== 32'hB000_0000 + 32'(k)) begin
                errors++; $display("[TB] FAIL ws_out got pc=%h instr=%h v=%b exp pc=%h", pc, instruction, instr_valid, 32'(4 * k + 4));
            end
        end
        clear_inputs();
    endtask

    // Leaves the DUT in HOLD with pc=4 presented and 0xC0DE_0001 buffered.
    task automatic enter_hold();
        do_reset();
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hC0DE_0000;
        tick();
        freeze = 1'b1; imem_rdata = 32'hC0DE_0001;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic test_freeze_hold();
        enter_hold();
        for (int c = 0; c < 3; c++) begin
            checks++; if (imem_req !== 1'b0 || pc !== 32'h4 || instruction !== 32'hC0DE_0000 || instr_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL hold_frozen got req=%b pc=%h instr=%h v=%b exp 0/4/c0de0000/1", imem_req, pc, instruction, instr_valid);
            end
            if (c < 2) tick();
        end
        freeze = 1'b0;
        tick();
        checks++; if (pc !== 32'h8 || instruction !== 32'hC0DE_0001 || instr_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL hold_release got pc=%h instr=%h v=%b exp 8/c0de0001/1", pc, instruction, instr_valid);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("[TB] FAIL hold_next_req got req=%b addr=%h exp 1/8", imem_req, imem_addr);
        end
        clear_inputs();
    endtask

    task automatic test_branch_discard();
        do_reset();
        tick();
        imem_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            imem_rdata = 32'(k);
            tick();
        end
        imem_ack = 1'b0;
        checks++; if (imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL br_pre_addr got=%h exp=20", imem_addr); end
        branch_taken = 1'b1; branch_address = 32'h0000_0103;
        tick();
        branch_taken = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || instr_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL br_discard got req=%b addr=%h v=%b exp 1/20/0", imem_req, imem_addr, instr_valid);
        end
        tick();
        checks++; if (imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL br_stable got=%h exp=20", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++; if (instruction === 32'hDEAD_BEEF || instr_valid !== 1'b0 || imem_addr !== 32'h100) begin
            errors++; $display("[TB] FAIL br_drop got instr=%h v=%b addr=%h exp 0/0/100", instruction, instr_valid, imem_addr);
        end
        imem_rdata = 32'h1234_5678;
        tick();
        checks++; if (pc !== 32'h104 || instruction !== 32'h1234_5678 || instr_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL br_first got pc=%h instr=%h v=%b exp 104/12345678/1", pc, instruction, instr_valid);
        end
        clear_inputs();
    endtask

    task automatic test_branch_in_hold();
        enter_hold();
        branch_taken = 1'b1; branch_address = 32'h0000_0202;
        tick();
        branch_taken = 1'b0;
        checks++; if (instr_valid !== 1'b0 || pc !== 32'h0 || instruction !== 32'h0) begin
            errors++; $display("[TB] FAIL bh_bubble got pc=%h instr=%h v=%b exp bubble", pc, instruction, instr_valid);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("[TB] FAIL bh_addr got req=%b addr=%h exp 1/200", imem_req, imem_addr);
        end
        freeze = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h5555_0000;
        tick();
        checks++; if (pc !== 32'h204 || instruction !== 32'h5555_0000 || instr_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL bh_resume got pc=%h instr=%h v=%b exp 204/55550000/1", pc, instruction, instr_valid);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_request();
        do_reset();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL rm_reset got req=%b v=%b addr=%h exp 0/0/0", imem_req, instr_valid, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        checks++; if (instr_valid !== 1'b0 || instruction !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL rm_late_ack got instr=%h v=%b req=%b addr=%h exp 0/0/1/0", instruction, instr_valid, imem_req, imem_addr);
        end
        branch_taken = 1'b1; branch_address = 32'hFFFF_FFFF; imem_rdata = 32'h1;
        tick();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL wrap_target got addr=%h v=%b exp fffffffc/0", imem_addr, instr_valid);
        end
        imem_rdata = 32'h7777_7777;
        tick();
        checks++; if (pc !== 32'h0 || imem_addr !== 32'h0 || instr_valid !== 1'b1 || instruction !== 32'h7777_7777) begin
            errors++; $display("[TB] FAIL wrap got pc=%h addr=%h v=%b instr=%h exp 0/0/1/77777777", pc, imem_addr, instr_valid, instruction);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        bit          fz, br, ack;
        logic [31:0] baddr, rdata;
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            fz    = ($urandom_range(0, 3) == 0);
            br    = ($urandom_range(0, 11) == 0);
            baddr = $urandom;
            ack   = imem_req && ($urandom_range(0, 2) != 0);
            rdata = $urandom;
            freeze = fz; branch_taken = br; branch_address = baddr;
            imem_ack = ack; imem_rdata = rdata;
            model_step(fz, br, baddr, ack, rdata);
            tick();
            checks++;
            if (pc !== m_pc || instruction !== m_instr || instr_valid !== m_valid ||
                imem_req !== m_busy || imem_addr !== m_addr) begin
                errors++;
                $display("[TB] FAIL rand[%0d] got pc=%h ins=%h v=%b req=%b addr=%h exp pc=%h ins=%h v=%b req=%b addr=%h",
                         n, pc, instruction, instr_valid, imem_req, imem_addr,
                         m_pc, m_instr, m_valid, m_busy, m_addr);
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_freeze_hold();
        test_branch_discard();
        test_branch_in_hold();
        test_reset_mid_request();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
